// File: rtl/inst_queue_mw.sv
// Multi-width circular instruction queue between fetch and dispatch, any DEPTH.
// Optional same-cycle fetch-to-dispatch bypass: define INST_QUEUE_BYPASS_EN.
`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 8
`endif
`ifndef N
`define N 3
`endif

module inst_queue_mw #(
  parameter int DEPTH      = `INST_BUFF_DEPTH,
  parameter int FETCH_W    = 4,
  parameter int DISPATCH_W = `N,
  parameter int DATA_W     = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [FETCH_W-1:0][DATA_W-1:0]       in_insts,
  input  logic [$clog2(FETCH_W+1)-1:0]         num_accept,
  input  logic [$clog2(DISPATCH_W+1)-1:0]      num_dispatch,
  output logic [DISPATCH_W-1:0][DATA_W-1:0]    out_insts,
  output logic [DISPATCH_W-1:0]                out_valid,
  output logic [$clog2(DEPTH+1)-1:0]           num_entries,
  output logic [$clog2(DEPTH+1)-1:0]           open_entries,
  output logic                                 err_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FI = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head, tail;

  logic [31:0] cnt, acc_req, disp_req, avail, room;
  logic [31:0] eff_disp, eff_acc, byp;
  logic        clamped;

  // Single conditional subtract: every caller keeps p + k below 2*DEPTH.
  function automatic logic [PW-1:0] wrap(input logic [31:0] p, input logic [31:0] k);
    logic [31:0] s;
    s = p + k;
    return (s >= 32'(DEPTH)) ? PW'(s - 32'(DEPTH)) : PW'(s);
  endfunction

  always_comb begin
    cnt      = 32'(num_entries);
    acc_req  = (32'(num_accept) > 32'(FETCH_W)) ? 32'(FETCH_W) : 32'(num_accept);
    disp_req = (32'(num_dispatch) > 32'(DISPATCH_W)) ? 32'(DISPATCH_W) : 32'(num_dispatch);
`ifdef INST_QUEUE_BYPASS_EN
    avail    = cnt + acc_req;
`else
    avail    = cnt;
`endif
    eff_disp = (disp_req > avail) ? avail : disp_req;
    room     = 32'(DEPTH) - cnt + eff_disp;
    eff_acc  = (acc_req > room) ? room : acc_req;
    // Packets dispatched straight from in_insts never touch storage.
    byp      = (eff_disp > cnt) ? eff_disp - cnt : 32'd0;
    clamped  = (eff_acc != 32'(num_accept)) || (eff_disp != 32'(num_dispatch));
  end

  always_comb begin
    logic [31:0] k;
    out_insts = '0;
    out_valid = '0;
    k         = '0;
    if (!flush) begin
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (32'(i) < cnt) begin
          out_insts[i] = mem[wrap(32'(head), 32'(i))];
          out_valid[i] = 1'b1;
        end
`ifdef INST_QUEUE_BYPASS_EN
        else if (32'(i) < cnt + acc_req) begin
          k            = 32'(i) - cnt;
          out_insts[i] = in_insts[k[FI-1:0]];
          out_valid[i] = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head         <= '0;
      tail         <= '0;
      num_entries  <= '0;
      open_entries <= CW'(DEPTH);
      for (int s = 0; s < DEPTH; s++) mem[s] <= '0;
      if (reset) err_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < DISPATCH_W; i++)
        if (32'(i) < eff_disp - byp) mem[wrap(32'(head), 32'(i))] <= '0;
      // Writes follow the clears so a slot freed and refilled this cycle keeps the new packet.
      for (int j = 0; j < FETCH_W; j++)
        if (32'(j) >= byp && 32'(j) < eff_acc)
          mem[wrap(32'(tail), 32'(j) - byp)] <= in_insts[j];
      head         <= wrap(32'(head), eff_disp - byp);
      tail         <= wrap(32'(tail), eff_acc - byp);
      num_entries  <= CW'(cnt + eff_acc - eff_disp);
      open_entries <= CW'(32'(DEPTH) - (cnt + eff_acc - eff_disp));
      if (clamped) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_queue_mw.sv
// Directed and random bench for inst_queue_mw with a packet-order scoreboard.
module tb_inst_queue_mw;
  localparam int DEPTH = 8;
  localparam int FW    = 4;
  localparam int DW    = 3;
  localparam int WD    = 32;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   flush = 1'b0;
  logic [FW-1:0][WD-1:0]  in_insts = '0;
  logic [2:0]             num_accept = '0;
  logic [1:0]             num_dispatch = '0;
  logic [DW-1:0][WD-1:0]  out_insts;
  logic [DW-1:0]          out_valid;
  logic [3:0]             num_entries;
  logic [3:0]             open_entries;
  logic                   err_overflow;

  int          checks = 0;
  int          errors = 0;
  logic [WD-1:0] sb[$];
  logic        err_exp = 1'b0;
  int unsigned seq = 0;

  inst_queue_mw #(.DEPTH(DEPTH), .FETCH_W(FW), .DISPATCH_W(DW), .DATA_W(WD)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_insts(in_insts),
    .num_accept(num_accept), .num_dispatch(num_dispatch), .out_insts(out_insts),
    .out_valid(out_valid), .num_entries(num_entries), .open_entries(open_entries),
    .err_overflow(err_overflow));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int acc, input int disp, input bit fl, input bit rs);
    logic [WD-1:0] pk[FW];
    logic [WD-1:0] lst[$];
    int sz, avail, room, ed, ea;
    for (int k = 0; k < FW; k++) begin
      seq++;
      pk[k] = 32'hA000_0000 + seq;
      in_insts[k] = pk[k];
    end
    num_accept   = 3'(acc);
    num_dispatch = 2'(disp);
    flush        = fl;
    reset        = rs;
    #1;
    if (!rs) begin
      lst = sb;
`ifdef INST_QUEUE_BYPASS_EN
      for (int k = 0; k < acc; k++) lst.push_back(pk[k]);
`endif
      for (int i = 0; i < DW; i++) begin
        check($sformatf("out_insts[%0d]", i), out_insts[i],
              (!fl && i < lst.size()) ? lst[i] : '0);
        check($sformatf("out_valid[%0d]", i), {31'b0, out_valid[i]},
              {31'b0, (!fl && i < lst.size())});
      end
    end
    if (rs) begin
      sb.delete();
      err_exp = 1'b0;
    end else if (fl) begin
      sb.delete();
    end else begin
      sz = sb.size();
`ifdef INST_QUEUE_BYPASS_EN
      avail = sz + acc;
`else
      avail = sz;
`endif
      ed   = (disp < avail) ? disp : avail;
      room = DEPTH - sz + ed;
      ea   = (acc < room) ? acc : room;
      if (ea != acc || ed != disp) err_exp = 1'b1;
      for (int k = 0; k < ea; k++) sb.push_back(pk[k]);
      repeat (ed) void'(sb.pop_front());
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    check("num_entries", {28'b0, num_entries}, WD'(sb.size()));
    check("open_entries", {28'b0, open_entries}, WD'(DEPTH - sb.size()));
    check("err_overflow", {31'b0, err_overflow}, {31'b0, err_exp});
  endtask

  initial begin
    @(posedge clock);
    #1;
    step(0, 0, 0, 1);
    // Fill, over-accept while full, then drain
    step(4, 0, 0, 0);
    step(4, 0, 0, 0);
    step(4, 0, 0, 0);
    step(4, 3, 0, 0);
    step(0, 3, 0, 0);
    // Flush with 5 entries keeps the sticky error
    step(4, 0, 1, 0);
    step(0, 0, 0, 0);
    // Dispatch from empty queue flags, reset clears
    step(0, 0, 0, 1);
    step(0, 2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    // Park head/tail at 6, then wrap both pointers together
    step(4, 0, 0, 0);
    step(2, 0, 0, 0);
    step(0, 3, 0, 0);
    step(0, 3, 0, 0);
    step(2, 0, 0, 0);
    step(4, 2, 0, 0);
    step(0, 0, 0, 0);
    // Same-cycle accept and dispatch from empty
    step(0, 0, 0, 1);
    step(4, 3, 0, 0);
    step(0, 0, 0, 0);
    for (int n = 0; n < 80; n++)
      step(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0), 1'b0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
